regfile_host_arbiter: RTL and testbench
=======================================

// Module: regfile_host_arbiter
// PURPOSE
//  Shares the 32x32 register file between the RISC-V core and the host (UART debug) command
//  path. Muxes the write port and read port A. Serialises single host reads/writes and a
//  full-register dump (x0..x31 streamed). Stalls the core while the host owns read port A.
//  Sits between core decode/writeback, the regfile and the host command decoder.
// PARAMETERS
//  DATA_W        32  register width
//  ADDR_W        5   register index width; NUM_REGS = 2**ADDR_W
//  STARVE_LIMIT  8   cycles a host write may wait on core writes before core_stall forces the port free
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       async active-low reset
//  core_write     in   1       core writeback enable
//  core_wrAddr    in   ADDR_W  core write index
//  core_wrData    in   DATA_W  core write data
//  core_rdAddrA   in   ADDR_W  core read index A
//  core_rdAddrB   in   ADDR_W  core read index B; always passed through
//  core_stall     out  1       core must hold its pipeline this cycle
//  host_req_valid in   1       host request valid
//  host_req_ready out  1       request accepted when valid&&ready
//  host_req_op    in   2       0=read, 1=write, 2=dump, 3=reserved (accepted, no action)
//  host_req_addr  in   ADDR_W  register index for read/write
//  host_req_data  in   DATA_W  write data
//  host_rsp_valid out  1       response valid; held until ready
//  host_rsp_ready in   1       host consumes response
//  host_rsp_addr  out  ADDR_W  index of returned register
//  host_rsp_data  out  DATA_W  register value
//  host_rsp_last  out  1       final beat (single read, or x31 of dump)
//  rf_write       out  1       regfile write enable
//  rf_wrAddr      out  ADDR_W  regfile write index
//  rf_wrData      out  DATA_W  regfile write data
//  rf_rdAddrA     out  ADDR_W  regfile read index A
//  rf_rdAddrB     out  ADDR_W  regfile read index B (= core_rdAddrB)
//  rf_rdDataA     in   DATA_W  regfile read data A; registered, valid 1 cycle after address
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including host_req_ready, core_stall, host_rsp_* and
//   the starve counter. Reset mid-transaction aborts it; no response is issued.
//  FSM states: IDLE, RD_ISSUE, RD_CAPT, RSP, WR_WAIT, DUMP_ISSUE, DUMP_CAPT, DUMP_RSP.
//  IDLE: host_req_ready=1. On accept: read->RD_ISSUE, write->WR_WAIT, dump->DUMP_ISSUE (idx=0),
//   reserved->IDLE.
//  RD_ISSUE/DUMP_ISSUE: rf_rdAddrA=host addr or idx; core_stall=1 -> *_CAPT.
//  RD_CAPT/DUMP_CAPT: core_stall=1. Capture rf_rdDataA into rsp_data and assert
//   host_rsp_valid next cycle. -> RSP / DUMP_RSP.
//  Forwarding: if rf_write && rf_wrAddr==issued addr && addr!=0 in the ISSUE cycle, the
//   captured value is that rf_wrData, not the stale RAM output.
//  x0 always returns 0.
//  RSP: hold rsp_* stable until host_rsp_ready; then -> IDLE. host_rsp_last=1.
//  DUMP_RSP: on ready, if idx==NUM_REGS-1 -> IDLE (last=1 on that beat), else idx++ -> DUMP_ISSUE.
//   core_stall=0 in RSP states. Core may run between dump beats.
//  Write port: core_write has priority. In WR_WAIT, a host write drives rf_write in the first
//   cycle core_write=0, then -> IDLE. No response for writes.
//   Starve counter increments per blocked cycle. At STARVE_LIMIT, core_stall=1; the core must
//   drop core_write next cycle and the host write then completes. Counter clears on exit.
//  Host write to x0: consumed in one cycle with rf_write=0.
//  Core write to x0: passed through; the regfile ignores it.
//  Outside ISSUE states: rf_rdAddrA=core_rdAddrA.
//  Outside a host write cycle: rf_write/rf_wrAddr/rf_wrData = core_*.
//  A new request is never accepted while a response is pending.
// STRUCTURE
//  Shared package regfile_pkg: DATA_W, ADDR_W, HOST_OP_{READ,WRITE,DUMP} encodings, FSM state
//   enum.
//  One sub-module is natural: regfile_port_mux (combinational selection of rf_* from owner).
//  The FSM, counters and response register stay in this module.
// TESTING
//  Host read x5 (holds 0xDEADBEEF), ready=1 -> rsp_valid 3 cycles after accept, data 0xDEADBEEF,
//   last=1; core_stall high exactly 2 cycles.
//  Host write x7=0x12345678, core idle -> rf_write 1 cycle, addr 7. A later host read of x7
//   returns 0x12345678.
//  Host write x3 while core_write held 1 -> stall asserted after 8 blocked cycles. Core drops
//   write; host write lands next cycle.
//  Host read x9 while core writes x9=0xA5A5A5A5 in the issue cycle -> rsp_data 0xA5A5A5A5.
//  Dump with host_rsp_ready toggling 1/0 -> 32 beats, addr 0..31 in order, x0=0, last only on
//   beat 31. Data is stable while ready=0.
//  rst_n pulsed low in DUMP_RSP at beat 10 -> all outputs 0 immediately; no further beats.
//   After release, host_req_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file host arbiter.
//   DATA_W / ADDR_W / NUM_REGS : register width, index width, register count
//   host_op_e                  : host command encodings carried on host_req_op
//   arb_state_e                : arbiter FSM states
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        HOST_OP_READ  = 2'd0,
        HOST_OP_WRITE = 2'd1,
        HOST_OP_DUMP  = 2'd2,
        HOST_OP_RSVD  = 2'd3
    } host_op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        RSP,
        WR_WAIT,
        DUMP_ISSUE,
        DUMP_CAPT,
        DUMP_RSP
    } arb_state_e;

endpackage

// File: rtl/regfile_port_mux.sv
// Combinational ownership mux for the regfile write port and read port A.
//   hostRdOwn/hostRdAddr               : host owns read port A this cycle
//   hostWrOwn/hostWrAddr/hostWrData    : host owns the write port this cycle
//   core_*                             : core-side write and read requests
//   rf_*                               : selected regfile controls (read B is a pass-through)
module regfile_port_mux
    import regfile_pkg::*;
(
    input  logic              hostRdOwn,
    input  logic [ADDR_W-1:0] hostRdAddr,
    input  logic              hostWrOwn,
    input  logic [ADDR_W-1:0] hostWrAddr,
    input  logic [DATA_W-1:0] hostWrData,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_wrAddr,
    input  logic [DATA_W-1:0] core_wrData,
    input  logic [ADDR_W-1:0] core_rdAddrA,
    input  logic [ADDR_W-1:0] core_rdAddrB,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic [ADDR_W-1:0] rf_rdAddrA,
    output logic [ADDR_W-1:0] rf_rdAddrB
);

    always_comb begin
        rf_write   = hostWrOwn ? 1'b1       : core_write;
        rf_wrAddr  = hostWrOwn ? hostWrAddr : core_wrAddr;
        rf_wrData  = hostWrOwn ? hostWrData : core_wrData;
        rf_rdAddrA = hostRdOwn ? hostRdAddr : core_rdAddrA;
        rf_rdAddrB = core_rdAddrB;
    end

endmodule

// File: rtl/regfile_host_arbiter.sv
// Shares the 32x32 register file between the core and the host debug command path.
//   clk, rst_n             : clock, async active-low reset
//   core_*                 : core write port, read indices, core_stall back-pressure
//   host_req_*             : host command (read / write / dump / reserved), valid-ready
//   host_rsp_*             : read/dump response beats, held until host_rsp_ready
//   rf_*                   : regfile write port, read indices, registered read data A
module regfile_host_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_wrAddr,
    input  logic [DATA_W-1:0] core_wrData,
    input  logic [ADDR_W-1:0] core_rdAddrA,
    input  logic [ADDR_W-1:0] core_rdAddrB,
    output logic              core_stall,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [1:0]        host_req_op,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_data,
    output logic              host_rsp_valid,
    input  logic              host_rsp_ready,
    output logic [ADDR_W-1:0] host_rsp_addr,
    output logic [DATA_W-1:0] host_rsp_data,
    output logic              host_rsp_last,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic [ADDR_W-1:0] rf_rdAddrA,
    output logic [ADDR_W-1:0] rf_rdAddrB,
    input  logic [DATA_W-1:0] rf_rdDataA
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state, stateNext;
    logic              alive;      // keeps host_req_ready low while in reset
    logic [ADDR_W-1:0] reqAddr;    // single-access index, or running dump index
    logic [DATA_W-1:0] reqData;
    logic              fwdHit;
    logic [DATA_W-1:0] fwdData;
    logic [ADDR_W-1:0] rspAddr;
    logic [DATA_W-1:0] rspData;
    logic [CNT_W-1:0]  starveCnt;
    logic              hostRdOwn, hostWrOwn, accept, starved, lastIdx;

    assign lastIdx = (reqAddr == ADDR_W'(NUM_REGS - 1));
    assign starved = (starveCnt == CNT_W'(STARVE_LIMIT));
    assign host_rsp_addr = rspAddr;
    assign host_rsp_data = rspData;

    always_comb begin
        stateNext      = state;
        hostRdOwn      = 1'b0;
        hostWrOwn      = 1'b0;
        core_stall     = 1'b0;
        host_req_ready = 1'b0;
        host_rsp_valid = 1'b0;
        host_rsp_last  = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                host_req_ready = alive;
                if (alive && host_req_valid) begin
                    accept = 1'b1;
                    case (host_op_e'(host_req_op))
                        HOST_OP_READ:  stateNext = RD_ISSUE;
                        HOST_OP_WRITE: stateNext = WR_WAIT;
                        HOST_OP_DUMP:  stateNext = DUMP_ISSUE;
                        default:       stateNext = IDLE;
                    endcase
                end
            end
            RD_ISSUE: begin
                hostRdOwn  = 1'b1;
                core_stall = 1'b1;
                stateNext  = RD_CAPT;
            end
            RD_CAPT: begin
                core_stall = 1'b1;
                stateNext  = RSP;
            end
            RSP: begin
                host_rsp_valid = 1'b1;
                host_rsp_last  = 1'b1;
                if (host_rsp_ready) stateNext = IDLE;
            end
            WR_WAIT: begin
                core_stall = starved;
                if (reqAddr == '0) begin
                    stateNext = IDLE;
                end else if (!core_write) begin
                    hostWrOwn = 1'b1;
                    stateNext = IDLE;
                end
            end
            DUMP_ISSUE: begin
                hostRdOwn  = 1'b1;
                core_stall = 1'b1;
                stateNext  = DUMP_CAPT;
            end
            DUMP_CAPT: begin
                core_stall = 1'b1;
                stateNext  = DUMP_RSP;
            end
            DUMP_RSP: begin
                host_rsp_valid = 1'b1;
                host_rsp_last  = lastIdx;
                if (host_rsp_ready) stateNext = lastIdx ? IDLE : DUMP_ISSUE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alive     <= 1'b0;
            reqAddr   <= '0;
            reqData   <= '0;
            fwdHit    <= 1'b0;
            fwdData   <= '0;
            rspAddr   <= '0;
            rspData   <= '0;
            starveCnt <= '0;
        end else begin
            state <= stateNext;
            alive <= 1'b1;
            if (accept) begin
                reqAddr <= (host_req_op == HOST_OP_DUMP) ? '0 : host_req_addr;
                reqData <= host_req_data;
            end
            // The RAM read issued this cycle returns pre-write data, so remember
            // a same-index core write and substitute it at capture.
            if (hostRdOwn) begin
                fwdHit  <= rf_write && (rf_wrAddr == reqAddr);
                fwdData <= rf_wrData;
            end
            if (state == RD_CAPT || state == DUMP_CAPT) begin
                rspAddr <= reqAddr;
                if (reqAddr == '0)  rspData <= '0;
                else if (fwdHit)    rspData <= fwdData;
                else                rspData <= rf_rdDataA;
            end
            if (state == DUMP_RSP && host_rsp_ready && !lastIdx) reqAddr <= reqAddr + 1'b1;
            if (stateNext != WR_WAIT)             starveCnt <= '0;
            else if (state == WR_WAIT && !starved) starveCnt <= starveCnt + 1'b1;
        end
    end

    regfile_port_mux uPortMux (
        .hostRdOwn    (hostRdOwn),
        .hostRdAddr   (reqAddr),
        .hostWrOwn    (hostWrOwn),
        .hostWrAddr   (reqAddr),
        .hostWrData   (reqData),
        .core_write   (core_write),
        .core_wrAddr  (core_wrAddr),
        .core_wrData  (core_wrData),
        .core_rdAddrA (core_rdAddrA),
        .core_rdAddrB (core_rdAddrB),
        .rf_write     (rf_write),
        .rf_wrAddr    (rf_wrAddr),
        .rf_wrData    (rf_wrData),
        .rf_rdAddrA   (rf_rdAddrA),
        .rf_rdAddrB   (rf_rdAddrB)
    );

endmodule

// File: tb/tb_regfile_host_arbiter.sv
module tb_regfile_host_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_write;
    logic [4:0]  core_wrAddr, core_rdAddrA, core_rdAddrB;
    logic [31:0] core_wrData;
    logic        core_stall;
    logic        host_req_valid, host_req_ready;
    logic [1:0]  host_req_op;
    logic [4:0]  host_req_addr;
    logic [31:0] host_req_data;
    logic        host_rsp_valid, host_rsp_ready, host_rsp_last;
    logic [4:0]  host_rsp_addr;
    logic [31:0] host_rsp_data;
    logic        rf_write;
    logic [4:0]  rf_wrAddr, rf_rdAddrA, rf_rdAddrB;
    logic [31:0] rf_wrData, rf_rdDataA;

    int nChecks = 0;
    int nFails  = 0;

    // Reference view of architectural register contents.
    logic [31:0] refRegs [32];

    always #5 clk = ~clk;

    regfile_host_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_write(core_write), .core_wrAddr(core_wrAddr), .core_wrData(core_wrData),
        .core_rdAddrA(core_rdAddrA), .core_rdAddrB(core_rdAddrB), .core_stall(core_stall),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_addr(host_rsp_addr), .host_rsp_data(host_rsp_data), .host_rsp_last(host_rsp_last),
        .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
        .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB), .rf_rdDataA(rf_rdDataA)
    );

    // Regfile environment: registered read of pre-write contents; x0 storage
    // returns junk so the arbiter's zero forcing is observable.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rf_write && rf_wrAddr != 5'd0) mem[rf_wrAddr] <= rf_wrData;
        rf_rdDataA <= (rf_rdAddrA == 5'd0) ? 32'hBAD0_0BAD : mem[rf_rdAddrA];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // All tasks start and end 1ns after a rising edge.
    task automatic send_req(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                            output bit acc);
        host_req_valid = 1'b1; host_req_op = op; host_req_addr = a; host_req_data = d;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_req_ready) begin acc = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        host_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic cw, input logic [4:0] cwa,
                           input logic [31:0] cwd, output logic [31:0] data,
                           output logic [4:0] ra, output logic last,
                           output int lat, output int stalls, output bit ok);
        bit acc, got;
        host_rsp_ready = 1'b1;
        send_req(2'd0, a, 32'd0, acc);
        core_write = cw; core_wrAddr = cwa; core_wrData = cwd;
        lat = 0; stalls = 0; got = 1'b0; data = '0; ra = '0; last = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (core_stall) stalls++;
            if (host_rsp_valid) begin
                got = 1'b1; data = host_rsp_data; ra = host_rsp_addr; last = host_rsp_last;
            end
            @(posedge clk); #1;
            core_write = 1'b0;
            if (got) break;
        end
        ok = acc && got;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, output logic wr,
                            output logic [4:0] wa, output logic [31:0] wd, output bit acc);
        send_req(2'd1, a, d, acc);
        @(negedge clk);
        wr = rf_write; wa = rf_wrAddr; wd = rf_wrData;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({host_req_ready, core_stall, host_rsp_valid, host_rsp_last, rf_write} !== 5'b0 ||
            host_rsp_addr !== 5'd0 || host_rsp_data !== 32'd0) begin
            nFails++;
            $display("FAIL reset_outputs: ready=%b stall=%b rspv=%b last=%b wr=%b addr=%h data=%h, all required 0",
                     host_req_ready, core_stall, host_rsp_valid, host_rsp_last, rf_write,
                     host_rsp_addr, host_rsp_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        nChecks++;
        if (host_req_ready !== 1'b1) begin
            nFails++; $display("FAIL reset_release_ready: got %b required 1", host_req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = (i == 5) ? 32'hDEADBEEF : $urandom;
            core_write = 1'b1; core_wrAddr = 5'(i); core_wrData = v;
            refRegs[i] = (i == 0) ? 32'd0 : v;
            @(negedge clk);
            if (i == 0 || i == 5) begin
                nChecks++;
                if (rf_write !== 1'b1 || rf_wrAddr !== 5'(i) || rf_wrData !== v) begin
                    nFails++;
                    $display("FAIL core_wr_passthru: got %b/%0d/%h required 1/%0d/%h",
                             rf_write, rf_wrAddr, rf_wrData, i, v);
                end
            end
            @(posedge clk); #1;
        end
        core_write = 1'b0;
    endtask

    task automatic test_read_x5();
        logic [31:0] d; logic [4:0] ra; logic last; int lat, st; bit ok;
        do_read(5'd5, 1'b0, 5'd0, 32'd0, d, ra, last, lat, st, ok);
        nChecks++;
        if (!ok || d !== 32'hDEADBEEF || ra !== 5'd5 || last !== 1'b1) begin
            nFails++;
            $display("FAIL read_x5: ok=%b data=%h addr=%0d last=%b required 1/deadbeef/5/1", ok, d, ra, last);
        end
        nChecks++;
        if (lat != 3 || st != 2) begin
            nFails++;
            $display("FAIL read_x5_timing: latency=%0d stalls=%0d required 3/2", lat, st);
        end
    endtask

    task automatic test_write_idle();
        logic wr; logic [4:0] wa; logic [31:0] wd, d; logic [4:0] ra; logic last;
        int lat, st; bit acc, ok;
        do_write(5'd7, 32'h12345678, wr, wa, wd, acc);
        nChecks++;
        if (!acc || wr !== 1'b1 || wa !== 5'd7 || wd !== 32'h12345678) begin
            nFails++;
            $display("FAIL host_write_x7: acc=%b wr=%b addr=%0d data=%h required 1/1/7/12345678", acc, wr, wa, wd);
        end
        @(negedge clk);
        nChecks++;
        if (rf_write !== 1'b0 || host_req_ready !== 1'b1) begin
            nFails++;
            $display("FAIL host_write_one_cycle: wr=%b ready=%b required 0/1", rf_write, host_req_ready);
        end
        @(posedge clk); #1;
        refRegs[7] = 32'h12345678;
        do_read(5'd7, 1'b0, 5'd0, 32'd0, d, ra, last, lat, st, ok);
        nChecks++;
        if (!ok || d !== refRegs[7]) begin
            nFails++; $display("FAIL readback_x7: got %h required %h", d, refRegs[7]);
        end
    endtask

    task automatic test_starve();
        logic [31:0] d; logic [4:0] ra; logic last; int lat, st; bit acc, ok;
        int blocked = 0;
        bit leak = 1'b0;
        core_write = 1'b1; core_wrAddr = 5'd10; core_wrData = 32'hC0DE_0010;
        refRegs[10] = 32'hC0DE_0010;
        send_req(2'd1, 5'd3, 32'h3333_AAAA, acc);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (core_stall) break;
            if (rf_wrAddr !== 5'd10 || rf_wrData !== 32'hC0DE_0010) leak = 1'b1;
            blocked++;
            @(posedge clk); #1;
        end
        nChecks++;
        if (!acc || blocked != 8) begin
            nFails++; $display("FAIL starve_count: blocked=%0d acc=%b required 8/1", blocked, acc);
        end
        nChecks++;
        if (leak || rf_wrAddr !== 5'd10) begin
            nFails++; $display("FAIL starve_core_priority: host took port early (addr=%0d) required 10", rf_wrAddr);
        end
        @(posedge clk); #1;
        core_write = 1'b0;
        @(negedge clk);
        nChecks++;
        if (rf_write !== 1'b1 || rf_wrAddr !== 5'd3 || rf_wrData !== 32'h3333_AAAA) begin
            nFails++;
            $display("FAIL starve_host_lands: got %b/%0d/%h required 1/3/3333aaaa", rf_write, rf_wrAddr, rf_wrData);
        end
        @(posedge clk); #1;
        @(negedge clk);
        nChecks++;
        if (core_stall !== 1'b0 || rf_write !== 1'b0 || host_req_ready !== 1'b1) begin
            nFails++;
            $display("FAIL starve_exit: stall=%b wr=%b ready=%b required 0/0/1", core_stall, rf_write, host_req_ready);
        end
        @(posedge clk); #1;
        refRegs[3] = 32'h3333_AAAA;
        do_read(5'd3, 1'b0, 5'd0, 32'd0, d, ra, last, lat, st, ok);
        nChecks++;
        if (!ok || d !== refRegs[3]) begin
            nFails++; $display("FAIL readback_x3: got %h required %h", d, refRegs[3]);
        end
        do_read(5'd10, 1'b0, 5'd0, 32'd0, d, ra, last, lat, st, ok);
        nChecks++;
        if (!ok || d !== refRegs[10]) begin
            nFails++; $display("FAIL readback_x10: got %h required %h", d, refRegs[10]);
        end
    endtask

    task automatic test_forward();
        logic [31:0] d; logic [4:0] ra; logic last; int lat, st; bit ok;
        do_read(5'd9, 1'b1, 5'd9, 32'hA5A5A5A5, d, ra, last, lat, st, ok);
        refRegs[9] = 32'hA5A5A5A5;
        nChecks++;
        if (!ok || d !== 32'hA5A5A5A5 || ra !== 5'd9) begin
            nFails++; $display("FAIL forward_x9: got %h addr %0d required a5a5a5a5 addr 9", d, ra);
        end
    endtask

    task automatic test_x0();
        logic [31:0] d, wd; logic [4:0] ra, wa; logic last, wr; int lat, st; bit ok, acc;
        do_read(5'd0, 1'b0, 5'd0, 32'd0, d, ra, last, lat, st, ok);
        nChecks++;
        if (!ok || d !== 32'd0) begin
            nFails++; $display("FAIL read_x0: got %h required 0", d);
        end
        do_write(5'd0, 32'hFFFF_FFFF, wr, wa, wd, acc);
        nChecks++;
        if (!acc || wr !== 1'b0 || host_req_ready !== 1'b1) begin
            nFails++; $display("FAIL write_x0: wr=%b ready=%b required 0/1", wr, host_req_ready);
        end
    endtask

    task automatic test_reserved();
        bit acc, bad;
        send_req(2'd3, 5'd4, 32'h5555_5555, acc);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (host_rsp_valid !== 1'b0 || rf_write !== 1'b0 || host_req_ready !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
        end
        nChecks++;
        if (!acc || bad) begin
            nFails++; $display("FAIL reserved_op: acc=%b side_effect=%b required 1/0", acc, bad);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int op;
            logic [4:0] a;
            logic [31:0] v;
            core_rdAddrA = 5'($urandom); core_rdAddrB = 5'($urandom);
            @(negedge clk);
            nChecks++;
            if (rf_rdAddrA !== core_rdAddrA || rf_rdAddrB !== core_rdAddrB) begin
                nFails++;
                $display("FAIL rd_passthru: got %0d/%0d required %0d/%0d", rf_rdAddrA, rf_rdAddrB,
                         core_rdAddrA, core_rdAddrB);
            end
            @(posedge clk); #1;
            op = int'($urandom_range(0, 1));
            a  = 5'($urandom);
            v  = $urandom;
            if (op == 0) begin
                logic [31:0] d; logic [4:0] ra; logic last; int lat, st; bit ok;
                logic cw; logic [4:0] cwa; logic [31:0] exp;
                cw  = 1'($urandom_range(0, 1));
                cwa = ($urandom_range(0, 1) == 1) ? a : 5'($urandom);
                do_read(a, cw, cwa, v, d, ra, last, lat, st, ok);
                if (cw && cwa != 5'd0) refRegs[cwa] = v;
                exp = (a == 5'd0) ? 32'd0 : refRegs[a];
                nChecks++;
                if (!ok || d !== exp || ra !== a || last !== 1'b1 || lat != 3) begin
                    nFails++;
                    $display("FAIL rand_read x%0d: got %h addr %0d last %b lat %0d required %h/%0d/1/3",
                             a, d, ra, last, lat, exp, a);
                end
            end else begin
                logic wr; logic [4:0] wa; logic [31:0] wd; bit acc;
                do_write(a, v, wr, wa, wd, acc);
                nChecks++;
                if (!acc || wr !== (a != 5'd0) || (a != 5'd0 && (wa !== a || wd !== v))) begin
                    nFails++;
                    $display("FAIL rand_write x%0d: got %b/%0d/%h required %b/%0d/%h",
                             a, wr, wa, wd, (a != 5'd0), a, v);
                end
                if (a != 5'd0) refRegs[a] = v;
            end
        end
        core_rdAddrA = 5'd0; core_rdAddrB = 5'd0;
    endtask

    task automatic test_dump();
        bit acc, prevValid, prevReady;
        logic [31:0] prevData;
        logic [4:0] prevAddr;
        int beat = 0;
        prevValid = 1'b0; prevReady = 1'b0; prevData = '0; prevAddr = '0;
        send_req(2'd2, 5'd17, 32'd0, acc);
        for (int cyc = 0; cyc < 400 && beat < 32; cyc++) begin
            host_rsp_ready = 1'(cyc % 2);
            @(negedge clk);
            if (host_rsp_valid) begin
                if (prevValid && !prevReady) begin
                    nChecks++;
                    if (host_rsp_data !== prevData || host_rsp_addr !== prevAddr) begin
                        nFails++;
                        $display("FAIL dump_hold: got %0d/%h required %0d/%h", host_rsp_addr,
                                 host_rsp_data, prevAddr, prevData);
                    end
                end
                nChecks++;
                if (core_stall !== 1'b0) begin
                    nFails++; $display("FAIL dump_rsp_stall: got %b required 0", core_stall);
                end
                if (host_rsp_ready) begin
                    nChecks++;
                    if (host_rsp_addr !== 5'(beat) || host_rsp_data !== refRegs[beat] ||
                        host_rsp_last !== (beat == 31)) begin
                        nFails++;
                        $display("FAIL dump_beat %0d: got %0d/%h/%b required %0d/%h/%b", beat,
                                 host_rsp_addr, host_rsp_data, host_rsp_last, beat,
                                 refRegs[beat], (beat == 31));
                    end
                    beat++;
                end
                prevValid = 1'b1; prevReady = host_rsp_ready;
                prevData = host_rsp_data; prevAddr = host_rsp_addr;
            end else begin
                prevValid = 1'b0;
            end
            @(posedge clk); #1;
        end
        host_rsp_ready = 1'b1;
        @(negedge clk);
        nChecks++;
        if (!acc || beat != 32 || host_rsp_valid !== 1'b0 || host_req_ready !== 1'b1) begin
            nFails++;
            $display("FAIL dump_complete: beats=%0d rspv=%b ready=%b required 32/0/1",
                     beat, host_rsp_valid, host_req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_dump();
        bit acc, found, extra;
        logic [31:0] d; logic [4:0] ra; logic last; int lat, st; bit ok;
        host_rsp_ready = 1'b1;
        found = 1'b0;
        send_req(2'd2, 5'd0, 32'd0, acc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (host_rsp_valid && host_rsp_addr == 5'd10) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        nChecks++;
        if (!acc || !found) begin
            nFails++; $display("FAIL dump_reach_beat10: found=%b required 1", found);
        end
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({host_req_ready, core_stall, host_rsp_valid, host_rsp_last} !== 4'b0 ||
            host_rsp_addr !== 5'd0 || host_rsp_data !== 32'd0) begin
            nFails++;
            $display("FAIL midreset_outputs: ready=%b stall=%b rspv=%b last=%b addr=%h data=%h, all required 0",
                     host_req_ready, core_stall, host_rsp_valid, host_rsp_last, host_rsp_addr, host_rsp_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (host_rsp_valid) extra = 1'b1;
        end
        nChecks++;
        if (extra || host_req_ready !== 1'b1) begin
            nFails++; $display("FAIL midreset_after: extra_beat=%b ready=%b required 0/1", extra, host_req_ready);
        end
        @(posedge clk); #1;
        do_read(5'd5, 1'b0, 5'd0, 32'd0, d, ra, last, lat, st, ok);
        nChecks++;
        if (!ok || d !== refRegs[5]) begin
            nFails++; $display("FAIL post_reset_read: got %h required %h", d, refRegs[5]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        core_write = 1'b0; core_wrAddr = '0; core_wrData = '0;
        core_rdAddrA = '0; core_rdAddrB = '0;
        host_req_valid = 1'b0; host_req_op = '0; host_req_addr = '0; host_req_data = '0;
        host_rsp_ready = 1'b1;
        test_reset();
        test_preload();
        test_read_x5();
        test_write_idle();
        test_starve();
        test_forward();
        test_x0();
        test_reserved();
        test_random();
        test_dump();
        test_reset_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
